// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel blocks (lamp driver and switch reader).
// Contents:
//   PANEL_NUM_SW : number of panel switch/lamp positions
//   idx_w()      : index width needed to address a given number of positions
//   cnt_w()      : debounce counter width for a given hold time in cycles
//   sw_event_t   : switch-change event record {index, pressed}
package panel_pkg;

   // One switch per lamp position; the lamp driver uses the same count.
   localparam int unsigned PANEL_NUM_SW = 11;

   // Bits needed to address n positions (at least one bit).
   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Counter width able to hold 0 .. dc-1; the counter clears at dc-1 so it never wraps.
   function automatic int unsigned cnt_w(input int unsigned dc);
      return (dc <= 2) ? 1 : $clog2(dc);
   endfunction

   localparam int unsigned PANEL_IDX_W = idx_w(PANEL_NUM_SW);

   // Event record as seen by the panel controller.
   typedef struct packed {
      logic [PANEL_IDX_W-1:0] index;
      logic                   pressed;
   } sw_event_t;

endpackage

// File: rtl/switch_debounce.sv
// One switch channel: 2-flop synchronizer, hold-time counter and stable level.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   i_sw         : raw asynchronous contact (1 = closed)
//   o_state      : debounced level (registered)
//   o_chg_c      : combinational strobe, high in the cycle whose edge flips o_state
//   o_lvl_c      : combinational, the level o_state takes when o_chg_c is high
module switch_debounce
   import panel_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic i_sw,
   output logic o_state,
   output logic o_chg_c,
   output logic o_lvl_c
);

   localparam int unsigned           CNT_W    = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_meta;
   logic             r_sync;
   logic             r_state;
   logic [CNT_W-1:0] r_cnt;

   logic             w_diff;
   logic             w_hit;

   assign w_diff = r_sync ^ r_state;
   // Last cycle of the hold window with the synchronized level still different.
   assign w_hit  = w_diff && (r_cnt == CNT_LAST);

   // Synchronizer, counter and stable level.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_meta  <= 1'b0;
         r_sync  <= 1'b0;
         r_state <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_meta <= i_sw;
         r_sync <= r_meta;
         if (!w_diff) begin
            // Back at (or still at) the stable level: restart the hold window.
            r_cnt <= '0;
         end else if (w_hit) begin
            r_state <= r_sync;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_state = r_state;
   assign o_chg_c = w_hit;
   assign o_lvl_c = r_sync;

endmodule

// File: rtl/panel_switch_reader.sv
// Front-panel switch reader: debounces each switch and queues one change event
// per debounced transition, drained by the panel controller over valid/ready.
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   switch_in      : raw switch contacts, 1 = closed
//   switch_state   : debounced level per switch
//   event_valid    : an event is presented
//   event_ready    : consumer accepts the presented event
//   event_index    : 0-based switch number of the presented event
//   event_pressed  : 1 = debounced 0->1 change, 0 = 1->0 change
//   overflow_err   : sticky, a switch changed again while its event was pending
module panel_switch_reader
   import panel_pkg::*;
#(
   parameter int unsigned NUM_SW          = PANEL_NUM_SW,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned IDX_W           = idx_w(NUM_SW)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NUM_SW-1:0] switch_in,
   output logic [NUM_SW-1:0] switch_state,
   output logic              event_valid,
   input  logic              event_ready,
   output logic [IDX_W-1:0]  event_index,
   output logic              event_pressed,
   output logic              overflow_err
);

   logic [NUM_SW-1:0] w_state;
   logic [NUM_SW-1:0] w_chg;
   logic [NUM_SW-1:0] w_lvl;

   logic [NUM_SW-1:0] r_pend;
   logic [NUM_SW-1:0] r_dir;
   logic              r_valid;
   logic [IDX_W-1:0]  r_idx;
   logic              r_pressed;
   logic              r_ovf;

   logic              w_free;
   logic              w_load;
   logic [NUM_SW-1:0] w_sel_oh;
   logic [NUM_SW-1:0] w_clr;
   logic [IDX_W-1:0]  w_sel_idx;
   logic              w_sel_dir;
   logic              w_ovf_hit;

   // One debounce channel per switch.
   for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
      switch_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_deb (
         .clock   (clock),
         .reset   (reset),
         .i_sw    (switch_in[g]),
         .o_state (w_state[g]),
         .o_chg_c (w_chg[g]),
         .o_lvl_c (w_lvl[g])
      );
   end

   // Output slot is free when empty or being drained this cycle.
   assign w_free   = !r_valid || event_ready;

   // Isolate the lowest pending bit: fixed priority, lowest index wins.
   assign w_sel_oh = r_pend & ~(r_pend - NUM_SW'(1));
   assign w_load   = w_free && (|r_pend);
   assign w_clr    = w_load ? w_sel_oh : '0;
   assign w_sel_dir = |(r_dir & w_sel_oh);

   // Encode the one-hot selection into an index.
   always_comb begin
      w_sel_idx = '0;
      for (int i = 0; i < NUM_SW; i++) begin
         if (w_sel_oh[i]) begin
            w_sel_idx = IDX_W'(i);
         end
      end
   end

   // A change on a switch whose event is still queued (and not leaving this edge).
   assign w_ovf_hit = |(w_chg & r_pend & ~w_clr);

   // Pending/direction bits, output slot and sticky overflow.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pend    <= '0;
         r_dir     <= '0;
         r_valid   <= 1'b0;
         r_idx     <= '0;
         r_pressed <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         // A fresh change re-arms its pend bit even if it is loaded this edge.
         r_pend <= (r_pend & ~w_clr) | w_chg;
         r_dir  <= (r_dir & ~w_chg) | (w_lvl & w_chg);

         if (w_ovf_hit) begin
            r_ovf <= 1'b1;
         end

         if (w_load) begin
            r_valid   <= 1'b1;
            r_idx     <= w_sel_idx;
            r_pressed <= w_sel_dir;
         end else if (w_free) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign switch_state  = w_state;
   assign event_valid   = r_valid;
   assign event_index   = r_idx;
   assign event_pressed = r_pressed;
   assign overflow_err  = r_ovf;

endmodule

// File: tb/tb_panel_switch_reader.sv
// Bench for panel_switch_reader with a 4-cycle debounce window.
module tb_panel_switch_reader;
   import panel_pkg::*;

   localparam int unsigned NSW = PANEL_NUM_SW;
   localparam int unsigned DC  = 4;
   localparam int unsigned IW  = PANEL_IDX_W;

   logic           clock;
   logic           reset;
   logic [NSW-1:0] switch_in;
   logic [NSW-1:0] switch_state;
   logic           event_valid;
   logic           event_ready;
   logic [IW-1:0]  event_index;
   logic           event_pressed;
   logic           overflow_err;

   panel_switch_reader #(
      .NUM_SW          (NSW),
      .DEBOUNCE_CYCLES (DC),
      .IDX_W           (IW)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .switch_in     (switch_in),
      .switch_state  (switch_state),
      .event_valid   (event_valid),
      .event_ready   (event_ready),
      .event_index   (event_index),
      .event_pressed (event_pressed),
      .overflow_err  (overflow_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp  = 0;
   int n_fail = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural model ----------------
   // A switch flips when the last DC synchronized samples (input delayed two
   // edges) all disagree with its stable level and none of them predate its
   // last flip or reset. Events: pending set + one output slot.
   logic [NSW-1:0] m_state, m_pend, m_dir;
   logic           m_valid, m_pressed, m_ovf;
   int             m_idx;
   int             edge_no = 0;
   int             last_flip [NSW];
   logic [NSW-1:0] rq [$];
   logic [NSW-1:0] sh [$];
   bit             cmp_en = 0;

   always @(posedge clock) begin
      logic [NSW-1:0] d;
      logic [NSW-1:0] chg;
      bit             all_diff;
      int             found;
      edge_no++;
      if (reset) begin
         m_state = '0; m_pend = '0; m_dir = '0;
         m_valid = 0; m_pressed = 0; m_ovf = 0; m_idx = 0;
         rq.delete(); rq.push_back('0); rq.push_back('0);
         sh.delete();
         for (int i = 0; i < NSW; i++) last_flip[i] = edge_no;
         cmp_en = 1;
      end else begin
         d = rq[0];
         rq.delete(0);
         rq.push_back(switch_in);
         sh.push_back(d);
         if (sh.size() > DC) sh.delete(0);
         chg = '0;
         for (int i = 0; i < NSW; i++) begin
            if (sh.size() == DC && (edge_no - last_flip[i]) >= int'(DC)) begin
               all_diff = 1;
               for (int k = 0; k < sh.size(); k++)
                  if (sh[k][i] == m_state[i]) all_diff = 0;
               chg[i] = all_diff;
            end
         end
         if (!m_valid || event_ready) begin
            found = -1;
            for (int i = 0; i < NSW; i++)
               if (m_pend[i] && found < 0) found = i;
            if (found >= 0) begin
               m_valid = 1; m_idx = found; m_pressed = m_dir[found]; m_pend[found] = 0;
            end else begin
               m_valid = 0;
            end
         end
         for (int i = 0; i < NSW; i++) begin
            if (chg[i]) begin
               if (m_pend[i]) m_ovf = 1;
               m_pend[i]  = 1;
               m_state[i] = ~m_state[i];
               m_dir[i]   = m_state[i];
               last_flip[i] = edge_no;
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clock) begin
      if (cmp_en) begin
         chk("model_state", 32'(switch_state), 32'(m_state));
         chk("model_valid", 32'(event_valid), 32'(m_valid));
         chk("model_ovf", 32'(overflow_err), 32'(m_ovf));
         if (m_valid) begin
            chk("model_index", 32'(event_index), 32'(m_idx));
            chk("model_pressed", 32'(event_pressed), 32'(m_pressed));
         end
      end
   end

   // Log of completed transfers.
   sw_event_t obs [$];
   always @(posedge clock) begin
      sw_event_t e;
      if (!reset && event_valid && event_ready) begin
         e.index   = event_index;
         e.pressed = event_pressed;
         obs.push_back(e);
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         @(negedge clock);
      end
   endtask

   task automatic wait_valid(input int budget);
      int n = 0;
      while (!event_valid && n < budget) begin
         tick(1);
         n++;
      end
      chk("wait_valid", 32'(event_valid), 32'd1);
   endtask

   initial begin
      int vcount;
      reset       = 1'b1;
      switch_in   = '0;
      event_ready = 1'b1;
      tick(3);
      chk("rst_state", 32'(switch_state), 32'd0);
      chk("rst_valid", 32'(event_valid), 32'd0);
      reset = 1'b0;

      // Idle
      tick(20);
      chk("idle_state", 32'(switch_state), 32'd0);
      chk("idle_valid", 32'(event_valid), 32'd0);
      chk("idle_ovf", 32'(overflow_err), 32'd0);

      // Clean press of switch 3
      obs.delete();
      switch_in[3] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick(1);
         if (k == 5) chk("press_state_c5", 32'(switch_state[3]), 32'd0);
         if (k == 6) begin
            chk("press_state_c6", 32'(switch_state[3]), 32'd1);
            chk("press_valid_c6", 32'(event_valid), 32'd0);
         end
         if (k == 7) begin
            chk("press_valid_c7", 32'(event_valid), 32'd1);
            chk("press_index_c7", 32'(event_index), 32'd3);
            chk("press_dir_c7", 32'(event_pressed), 32'd1);
         end
         if (k == 8) chk("press_valid_c8", 32'(event_valid), 32'd0);
      end
      chk("press_nevents", 32'(obs.size()), 32'd1);
      switch_in[3] = 1'b0;
      tick(12);

      // Glitch rejection on switch 5
      obs.delete();
      switch_in[5] = 1'b1;
      tick(3);
      switch_in[5] = 1'b0;
      tick(12);
      chk("glitch_state", 32'(switch_state[5]), 32'd0);
      chk("glitch_nevents", 32'(obs.size()), 32'd0);
      switch_in[5] = 1'b1;
      tick(6);
      switch_in[5] = 1'b0;
      tick(14);
      chk("accept_nevents", 32'(obs.size()), 32'd2);
      if (obs.size() >= 2) begin
         chk("accept_ev0", 32'({obs[0].index, obs[0].pressed}), 32'({4'd5, 1'b1}));
         chk("accept_ev1", 32'({obs[1].index, obs[1].pressed}), 32'({4'd5, 1'b0}));
      end

      // Priority and backpressure: switches 9 and 2 together
      obs.delete();
      event_ready  = 1'b0;
      switch_in[9] = 1'b1;
      switch_in[2] = 1'b1;
      wait_valid(20);
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", 32'(event_valid), 32'd1);
         chk("bp_index", 32'(event_index), 32'd2);
         tick(1);
      end
      event_ready = 1'b1;
      tick(1);
      chk("prio_second_valid", 32'(event_valid), 32'd1);
      chk("prio_second_index", 32'(event_index), 32'd9);
      tick(1);
      chk("prio_drained", 32'(event_valid), 32'd0);
      chk("prio_nevents", 32'(obs.size()), 32'd2);
      if (obs.size() >= 2) begin
         chk("prio_ev0", 32'(obs[0].index), 32'd2);
         chk("prio_ev1", 32'(obs[1].index), 32'd9);
      end
      switch_in[9] = 1'b0;
      switch_in[2] = 1'b0;
      tick(12);

      // Overflow: slot held by switch 0, switch 7 pressed then released
      event_ready  = 1'b0;
      switch_in[0] = 1'b1;
      wait_valid(20);
      chk("ovf_slot_index", 32'(event_index), 32'd0);
      switch_in[7] = 1'b1;
      tick(6);
      switch_in[7] = 1'b0;
      tick(10);
      chk("ovf_set", 32'(overflow_err), 32'd1);
      chk("ovf_slot_held", 32'(event_index), 32'd0);
      event_ready = 1'b1;
      tick(1);
      chk("ovf_ev_valid", 32'(event_valid), 32'd1);
      chk("ovf_ev_index", 32'(event_index), 32'd7);
      chk("ovf_ev_dir", 32'(event_pressed), 32'd0);
      tick(1);
      chk("ovf_single", 32'(event_valid), 32'd0);
      chk("ovf_sticky", 32'(overflow_err), 32'd1);
      switch_in[0] = 1'b0;
      tick(12);

      // Reset mid-handshake and mid-debounce
      event_ready  = 1'b0;
      switch_in[1] = 1'b1;
      wait_valid(20);
      switch_in[4] = 1'b1;
      tick(3);
      reset     = 1'b1;
      switch_in = '0;
      tick(1);
      chk("mid_rst_state", 32'(switch_state), 32'd0);
      chk("mid_rst_valid", 32'(event_valid), 32'd0);
      chk("mid_rst_index", 32'(event_index), 32'd0);
      chk("mid_rst_dir", 32'(event_pressed), 32'd0);
      chk("mid_rst_ovf", 32'(overflow_err), 32'd0);
      reset       = 1'b0;
      event_ready = 1'b1;
      vcount = 0;
      for (int k = 0; k < 15; k++) begin
         tick(1);
         if (event_valid) vcount++;
      end
      chk("post_rst_no_event", 32'(vcount), 32'd0);
      chk("post_rst_state", 32'(switch_state), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/panel_switch_reader.md
Name: panel_switch_reader

Overview:
- Input-side counterpart to the lamp driver: samples the front-panel switch bank and turns raw contacts into clean levels plus a stream of switch-change events.
- Per switch: 2-flop synchronizer, then a debounce counter, giving a stable level.
- Each debounced change queues one event (index plus direction) for the panel controller, which drains events over a valid/ready handshake.

Parameters:
- NUM_SW, 11, number of switch inputs; one per lamp position.
- DEBOUNCE_CYCLES, 16, consecutive clock cycles a synchronized level must hold before it is accepted; legal range 2..65535.
- IDX_W, 4, event index width; must satisfy 2**IDX_W >= NUM_SW.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- switch_in  input  NUM_SW  raw asynchronous switch contacts; 1 = closed.
- switch_state  output  NUM_SW  debounced level per switch.
- event_valid  output  1  an event is presented.
- event_ready  input  1  consumer accepts the event; transfer occurs when valid and ready are both high.
- event_index  output  IDX_W  switch number of the presented event (0-based).
- event_pressed  output  1  1 = debounced 0->1 change, 0 = 1->0 change.
- overflow_err  output  1  sticky; a switch changed again while its previous event was still pending.

Behaviour:
- Reset (sampled at a clock edge):
  - Clears synchronizer flops, all counters, switch_state, pending and direction bits.
  - Forces event_valid, event_index, event_pressed and overflow_err to 0.
  - A reset asserted mid-debounce or mid-handshake discards all in-flight state, with no event emitted.
- Synchronizer:
  - sync = two-stage flop chain per bit.
  - sync reflects switch_in 2 cycles after it changes.
- Debounce, per switch i:
  - If sync[i] == switch_state[i]: cnt[i] is cleared to 0.
  - Otherwise cnt[i] increments.
  - When cnt[i] == DEBOUNCE_CYCLES-1 and sync[i] still differs: switch_state[i] toggles, cnt[i] clears, and pend[i]=1, dir[i]=new level are set at that edge.
  - Any glitch back to the stable level before the threshold restarts the count from 0.
  - Counter width is ceil(log2(DEBOUNCE_CYCLES)); the counter never wraps because it is cleared at the threshold.
  - Latency: a clean change at switch_in reaches switch_state exactly 2 + DEBOUNCE_CYCLES cycles later.
- Event selection:
  - The output slot is free when event_valid==0, or when event_valid && event_ready.
  - When the slot is free and any pend bit is set, the lowest pending index is loaded into event_index/event_pressed.
  - At that edge, event_valid=1 and that pend bit is cleared.
  - Fixed priority, lowest index wins.
  - A pend bit set at edge N is first presentable on event_valid after edge N+1; minimum latency is 1 cycle after the state flip.
  - Back-to-back transfers every cycle are supported while pend bits remain.
  - With no pending events, a transfer drops event_valid at the next edge.
- Handshake:
  - While event_valid && !event_ready, event_index and event_pressed hold stable and event_valid stays high.
  - event_valid never drops without a transfer, except on reset.
- Boundary cases:
  - A new debounced change on switch i while pend[i]==1: dir[i] is overwritten with the new level, pend[i] stays 1, overflow_err is set.
  - The same applies when pend[i] is being loaded into the slot at that same edge: the new setting wins, pend[i]=1 remains, and no overflow is raised.
  - Simultaneous threshold hits on several switches in one cycle each set their own pend bit; events then drain in index order.
  - overflow_err clears only on reset.

Decomposition:
- Package panel_pkg:
  - NUM_SW default (11).
  - IDX_W derivation function (clog2).
  - Debounce-counter width function.
  - A typedef for the event record {index, pressed}.
- The lamp driver and this reader share NUM_SW from the package.
- Sub-module switch_debounce: one channel (2-flop sync, counter, stable level, change strobe, new level).
  - Instantiated NUM_SW times.
  - The top level holds the pend/dir bits, priority select, output register and overflow flag.

Test Plan (DEBOUNCE_CYCLES=4, NUM_SW=11, event_ready=1 unless stated):
- Reset then idle: switch_in=0 for 20 cycles -> switch_state=0, event_valid=0, overflow_err=0 throughout.
- Clean press: switch_in[3] 0->1 at cycle 0 -> switch_state[3]=1 at cycle 6; a single event at cycle 7 with index=3, pressed=1; event_valid low at cycle 8.
- Glitch rejection: switch_in[5] high for 3 cycles then low -> no change on switch_state[5] and no event. Repeat with 4+2 cycles high -> accepted, with press and release events in order.
- Priority and backpressure: switch_in[9] and switch_in[2] rise in the same cycle, event_ready=0 -> event_valid=1 with index=2, held stable for 5 cycles. Raise event_ready -> index=2 transfers, then index=9 on the next cycle.
- Overflow: event_ready=0; press then release switch 7 (6 cycles each) -> overflow_err=1; the single pending event for index 7 has pressed=0.
- Reset mid-operation: assert reset while event_valid=1 and switch 4 is mid-debounce -> all outputs 0 next edge; no stale event after reset deasserts.
